// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core definitions: PC-select encoding (also used by the decoder),
// PC sequencer state encoding and the default reset vector.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    INCREMENT = 2'b00,
    BRANCH    = 2'b01,
    JUMP      = 2'b10,
    JR        = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DELAY  = 2'b01,
    HALTED = 2'b10
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/ALU <-> PC sequencer bundle.
//   master: decoder side, drives stall/pc_sel/is_true/extended_imm/j_addr/reg_data_a
//   slave : sequencer side, drives pc/link_pc/in_delay_slot/active
interface pc_sequencer_if;
  import mips_cpu_pkg::*;

  logic        stall;
  pc_sel_t     pc_sel;
  logic        is_true;
  logic [31:0] extended_imm;
  logic [25:0] j_addr;
  logic [31:0] reg_data_a;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        in_delay_slot;
  logic        active;

  modport master (
    output stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
    input  pc, link_pc, in_delay_slot, active
  );

  modport slave (
    input  stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
    output pc, link_pc, in_delay_slot, active
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC arithmetic.
//   in : pc, pc_sel, is_true, extended_imm (words), j_addr, reg_data_a
//   out: inc (pc+4), target (branch/jump/jr address), redirect (control transfer taken)
// All sums wrap at 32 bits; JR targets pass through unaligned.
module pc_target_calc
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  pc_sel_t     pc_sel,
  input  logic        is_true,
  input  logic [31:0] extended_imm,
  input  logic [25:0] j_addr,
  input  logic [31:0] reg_data_a,
  output logic [31:0] inc,
  output logic [31:0] target,
  output logic        redirect
);

  logic [31:0] br, jmp;

  always_comb begin
    inc = pc + 32'd4;
    br  = inc + (extended_imm << 2);
    // jump region comes from the delay-slot address, not the jump itself
    jmp = {inc[31:28], j_addr, 2'b00};
    target   = inc;
    redirect = 1'b0;
    case (pc_sel)
      BRANCH:  begin target = br;         redirect = is_true; end
      JUMP:    begin target = jmp;        redirect = 1'b1;    end
      JR:      begin target = reg_data_a; redirect = 1'b1;    end
      default: begin target = inc;        redirect = 1'b0;    end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with MIPS branch-delay-slot sequencing, stall
// support and halt detection.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : stall/pc_sel/is_true/extended_imm/j_addr/reg_data_a in;
//                pc, link_pc, in_delay_slot, active out
// DELAY_SLOT=1 executes one instruction after a redirect before the target;
// DELAY_SLOT=0 redirects on the next edge.
module pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
  parameter bit          DELAY_SLOT   = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  logic [31:0] pc_q, pend_q;
  pc_state_t   state_q;
  logic [31:0] inc, target;
  logic        redirect;

  pc_target_calc u_calc (
    .pc           (pc_q),
    .pc_sel       (bus.pc_sel),
    .is_true      (bus.is_true),
    .extended_imm (bus.extended_imm),
    .j_addr       (bus.j_addr),
    .reg_data_a   (bus.reg_data_a),
    .inc          (inc),
    .target       (target),
    .redirect     (redirect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'h0;
      state_q <= RUN;
    end else if (!bus.stall) begin
      case (state_q)
        RUN: begin
          if (!redirect) begin
            pc_q <= inc;
          end else if (DELAY_SLOT) begin
            pc_q    <= inc;
            pend_q  <= target;
            state_q <= DELAY;
          end else if (target == HALT_ADDR) begin
            pc_q    <= HALT_ADDR;
            state_q <= HALTED;
          end else begin
            pc_q <= target;
          end
        end
        // delay-slot instruction's own redirect is deliberately dropped
        DELAY: begin
          pc_q    <= pend_q;
          state_q <= (pend_q == HALT_ADDR) ? HALTED : RUN;
        end
        HALTED:  pc_q <= HALT_ADDR;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.link_pc       = pc_q + (DELAY_SLOT ? 32'd8 : 32'd4);
  assign bus.in_delay_slot = (state_q == DELAY);
  assign bus.active        = (state_q != HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import mips_cpu_pkg::*;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] HALT = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus_d();   // DELAY_SLOT=1
  pc_sequencer_if bus_i();   // DELAY_SLOT=0

  pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(HALT), .DELAY_SLOT(1'b1))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));
  pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(HALT), .DELAY_SLOT(1'b0))
    dut_i (.clk(clk), .rst_n(rst_n), .bus(bus_i));

  // common stimulus, fanned out to both DUTs
  logic        s_stall;
  pc_sel_t     s_sel;
  logic        s_true;
  logic [31:0] s_imm;
  logic [25:0] s_ja;
  logic [31:0] s_rd;

  always_comb begin
    bus_d.stall = s_stall; bus_d.pc_sel = s_sel; bus_d.is_true = s_true;
    bus_d.extended_imm = s_imm; bus_d.j_addr = s_ja; bus_d.reg_data_a = s_rd;
    bus_i.stall = s_stall; bus_i.pc_sel = s_sel; bus_i.is_true = s_true;
    bus_i.extended_imm = s_imm; bus_i.j_addr = s_ja; bus_i.reg_data_a = s_rd;
  end

  int checks = 0;
  int errors = 0;

  // reference model: [0]=delay-slot unit, [1]=immediate unit.
  // A taken transfer on the delay-slot unit schedules its target for after
  // the following instruction; once the halt address is reached, nothing moves.
  logic [31:0] m_pc   [2];
  logic        m_halt [2];
  logic        m_sched[2];
  logic [31:0] m_tgt  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = RV; m_halt[k] = 1'b0; m_sched[k] = 1'b0; m_tgt[k] = 32'h0;
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt, dest;
    logic        taken;
    if (s_stall) return;
    for (int k = 0; k < 2; k++) begin
      if (m_halt[k]) continue;
      if (m_sched[k]) begin
        m_sched[k] = 1'b0;
        m_pc[k]    = m_tgt[k];
        m_halt[k]  = (m_pc[k] == HALT);
        continue;
      end
      nxt = m_pc[k] + 32'd4;
      taken = 1'b1;
      dest  = nxt;
      if (s_sel == BRANCH) begin
        taken = s_true;
        dest  = nxt + s_imm * 32'd4;
      end else if (s_sel == JUMP) begin
        dest = (nxt & 32'hF000_0000) + 32'(s_ja) * 32'd4;
      end else if (s_sel == JR) begin
        dest = s_rd;
      end else begin
        taken = 1'b0;
      end
      if (!taken) m_pc[k] = nxt;
      else if (k == 0) begin
        m_pc[k] = nxt; m_sched[k] = 1'b1; m_tgt[k] = dest;
      end else begin
        m_pc[k] = dest; m_halt[k] = (dest == HALT);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("d.pc",     bus_d.pc,                    m_pc[0]);
    chk("d.link",   bus_d.link_pc,               m_pc[0] + 32'd8);
    chk("d.ds",     32'(bus_d.in_delay_slot),    32'(m_sched[0]));
    chk("d.active", 32'(bus_d.active),           32'(!m_halt[0]));
    chk("i.pc",     bus_i.pc,                    m_pc[1]);
    chk("i.link",   bus_i.link_pc,               m_pc[1] + 32'd4);
    chk("i.ds",     32'(bus_i.in_delay_slot),    32'(m_sched[1]));
    chk("i.active", 32'(bus_i.active),           32'(!m_halt[1]));
  endtask

  task automatic drive(input pc_sel_t sel, input logic t, input logic [31:0] imm,
                       input logic [25:0] ja, input logic [31:0] rd, input logic st);
    s_sel = sel; s_true = t; s_imm = imm; s_ja = ja; s_rd = rd; s_stall = st;
  endtask

  // called at a negedge; inputs already driven
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic step(input pc_sel_t sel, input logic t, input logic [31:0] imm,
                      input logic [25:0] ja, input logic [31:0] rd, input logic st);
    drive(sel, t, imm, ja, rd, st);
    tick();
  endtask

  task automatic inc_step();
    step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
  endtask

  // reset asserted mid-cycle, released at the following negedge
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.d.pc", bus_d.pc, RV);
    chk("rst.d.ds", 32'(bus_d.in_delay_slot), 32'h0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset.pc", bus_d.pc, RV);
    chk("reset.active", 32'(bus_d.active), 32'h1);
    check_model();

    // 1: sequential fetch
    inc_step(); chk("t1.pc4", bus_d.pc, 32'hBFC0_0004);
    inc_step(); chk("t1.pc8", bus_d.pc, 32'hBFC0_0008);
    inc_step(); chk("t1.pcC", bus_d.pc, 32'hBFC0_000C);
    chk("t1.link", bus_d.link_pc, 32'hBFC0_0014);
    inc_step(); chk("t1.pc10", bus_d.pc, 32'hBFC0_0010);

    // 2: taken backward branch
    step(BRANCH, 1'b1, 32'hFFFF_FFFC, 26'h0, 32'h0, 1'b0);
    chk("t2.slot_pc", bus_d.pc, 32'hBFC0_0014);
    chk("t2.slot_ds", 32'(bus_d.in_delay_slot), 32'h1);
    inc_step();
    chk("t2.tgt_pc", bus_d.pc, 32'hBFC0_0004);
    chk("t2.tgt_ds", 32'(bus_d.in_delay_slot), 32'h0);

    // 3: not-taken branch, then jump region from pc+4
    step(JR, 1'b0, 32'h0, 26'h0, 32'h0040_0000, 1'b0); inc_step();
    chk("t3.at400000", bus_d.pc, 32'h0040_0000);
    step(BRANCH, 1'b0, 32'h0000_0100, 26'h0, 32'h0, 1'b0);
    chk("t3.nt_pc", bus_d.pc, 32'h0040_0004);
    chk("t3.nt_ds", 32'(bus_d.in_delay_slot), 32'h0);
    step(JR, 1'b0, 32'h0, 26'h0, 32'h8FFF_FFFC, 1'b0); inc_step();
    step(JUMP, 1'b0, 32'h0, 26'h000_0010, 32'h0, 1'b0);
    chk("t3.j_slot", bus_d.pc, 32'h9000_0000);
    inc_step();
    chk("t3.j_tgt", bus_d.pc, 32'h9000_0040);

    // 4: JR to halt address
    step(JR, 1'b0, 32'h0, 26'h0, 32'hBFC0_0020, 1'b0); inc_step();
    step(JR, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    chk("t4.slot", bus_d.pc, 32'hBFC0_0024);
    inc_step();
    chk("t4.halt_pc", bus_d.pc, 32'h0);
    chk("t4.halt_act", 32'(bus_d.active), 32'h0);
    step(JUMP, 1'b0, 32'h0, 26'h0AB_CDEF, 32'h0, 1'b0);
    step(JUMP, 1'b0, 32'h0, 26'h0AB_CDEF, 32'h0, 1'b0);
    chk("t4.stay_pc", bus_d.pc, 32'h0);

    // 5: stall across the delay slot with a jump presented
    reset_pulse();
    step(BRANCH, 1'b1, 32'h0000_0008, 26'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(JUMP, 1'b0, 32'h0, 26'h111_1111, 32'h0, 1'b1);
      chk("t5.stall_pc", bus_d.pc, 32'hBFC0_0004);
      chk("t5.stall_ds", 32'(bus_d.in_delay_slot), 32'h1);
    end
    step(JUMP, 1'b0, 32'h0, 26'h111_1111, 32'h0, 1'b0);
    chk("t5.tgt", bus_d.pc, 32'hBFC0_0024);

    // 6: async reset while in DELAY, then immediate-redirect unit
    step(BRANCH, 1'b1, 32'h0000_0040, 26'h0, 32'h0, 1'b0);
    chk("t6.in_delay", 32'(bus_d.in_delay_slot), 32'h1);
    reset_pulse();
    step(BRANCH, 1'b1, 32'h0000_0004, 26'h0, 32'h0, 1'b0);
    chk("t6.nods_pc", bus_i.pc, 32'hBFC0_0014);
    chk("t6.nods_ds", 32'(bus_i.in_delay_slot), 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [31:0] rd;
      if ($urandom_range(0, 40) == 0) reset_pulse();
      r  = int'($urandom_range(0, 63)) - 32;
      rd = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      step(pc_sel_t'($urandom_range(0, 3)), 1'($urandom), 32'(r),
           26'($urandom), rd, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised, registered program-counter unit for the MIPS core. It holds the PC and computes the next PC for increment, branch, jump and jump-register instructions. It implements the MIPS branch delay slot as a small state machine and supports pipeline stalls. It detects a jump to the halt address and then deasserts `active`. It drives the instruction-fetch address and the link value for JAL/JALR/BxxAL.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000: PC value loaded on reset.
- HALT_ADDR, 32'h0000_0000: redirect target that ends execution.
- DELAY_SLOT, 1: 1 = MIPS delay-slot semantics; 0 = immediate redirect (debug/bring-up mode).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  1 = hold all state this cycle.
- pc_sel  in  2  00 INCREMENT, 01 BRANCH, 10 JUMP, 11 JR; from decoder, describes the instruction at `pc`.
- is_true  in  1  branch condition from the ALU; used only when pc_sel=BRANCH.
- extended_imm  in  32  sign-extended branch offset, in words.
- j_addr  in  26  instr[25:0].
- reg_data_a  in  32  rs value, for JR/JALR.
- pc  out  32  current fetch address.
- link_pc  out  32  return address: pc+8 if DELAY_SLOT=1, else pc+4; combinational from `pc`.
- in_delay_slot  out  1  1 while the instruction at `pc` is a delay-slot instruction.
- active  out  1  1 while executing; 0 once halted.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VECTOR, state=RUN, pending_target=0, in_delay_slot=0, active=1. Takes effect immediately, including mid-redirect; a pending target is discarded.
- Target arithmetic, all 32-bit with wrap-around (no overflow detection):
  - inc = pc+4.
  - br = inc + (extended_imm<<2). Shift is applied before the add.
  - jmp = {inc[31:28], j_addr, 2'b00}.
  - jr = reg_data_a.
- redirect = (pc_sel==BRANCH && is_true) || pc_sel==JUMP || pc_sel==JR.
- target = br / jmp / jr, selected by pc_sel.
- Branch not taken behaves as INCREMENT.
- States: RUN, DELAY, HALTED. All updates occur on the clk rising edge only when stall=0. With stall=1, pc, state and pending_target all hold.
- RUN:
  - No redirect: pc<=inc.
  - Redirect with DELAY_SLOT=1: pc<=inc, pending_target<=target, state<=DELAY.
  - Redirect with DELAY_SLOT=0: if target==HALT_ADDR then pc<=HALT_ADDR, state<=HALTED; else pc<=target.
- DELAY (in_delay_slot=1):
  - Any redirect presented by the delay-slot instruction is ignored.
  - pc<=pending_target.
  - state<=HALTED if pending_target==HALT_ADDR, else RUN.
- HALTED: pc holds at HALT_ADDR, active=0, inputs ignored; only reset leaves this state.
- in_delay_slot = (state==DELAY); active = (state!=HALTED). Both are registered state decodes.
- Latency: a redirect becomes visible on `pc` 2 unstalled edges after the branch is at `pc` (DELAY_SLOT=1), or 1 edge (DELAY_SLOT=0).
- Stall in DELAY: the state holds, so the redirect is preserved across any number of stall cycles.
- A JR to an unaligned address is passed through unchanged; alignment faults are handled elsewhere.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - the pc_sel_t enum (INCREMENT/BRANCH/JUMP/JR), also used by the decoder;
  - the pc_state_t enum (RUN/DELAY/HALTED);
  - the RESET_VECTOR default constant.
- One combinational sub-module, pc_target_calc, takes pc, pc_sel, is_true, extended_imm, j_addr and reg_data_a, and produces inc, target and redirect.
- The sequential FSM and registers stay in pc_sequencer.

Test Plan:
1. Reset then 3 unstalled INCREMENT cycles -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; active=1; link_pc=BFC00014 at the last step.
2. At pc=BFC00010, BRANCH is_true=1, imm=FFFFFFFC -> next pc=BFC00014 with in_delay_slot=1, then pc=BFC00004 (=BFC00014-16), in_delay_slot=0.
3. BRANCH is_true=0 at pc=00400000 -> pc=00400004, state stays RUN. JUMP at pc=8FFFFFFC, j_addr=0000010 -> delay slot at pc=90000000, then pc=90000040 (upper bits taken from pc+4).
4. JR reg_data_a=0 at pc=BFC00020 -> pc=BFC00024 (delay slot), then pc=0, active=0; further JUMP inputs leave pc=0.
5. Taken branch, then stall=1 for 3 cycles during DELAY with a JUMP presented on the inputs -> pc and in_delay_slot hold; after stall=0, pc=the original branch target (the JUMP is ignored).
6. rst_n pulsed low asynchronously (mid-cycle) while in DELAY -> pc=BFC00000 immediately, in_delay_slot=0. With DELAY_SLOT=0, a taken branch redirects on the next edge.
